// File: rtl/circ_buf_ctrl.sv
// rtl/circ_buf_ctrl.sv - occupancy/handshake controller for a COLUMNS-deep circular buffer
// Define CIRC_BUF_ERR_FLAG_EN to add the err_sticky refused-request flag.
module circ_buf_ctrl #(
   parameter int  COLUMNS   = 32,
   parameter int  PAR_WRITE = 4,
   parameter int  PAR_READ  = 1,
   localparam int CW        = $clog2(COLUMNS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_req,
   output logic          wr_ready,
   input  logic [CW-1:0] write_ptr,
   output logic          wen,
   output logic          updateWP,
   output logic [CW-1:0] wr_addr,
   input  logic          rd_req,
   output logic          rd_valid,
   output logic          ren,
   output logic [CW-1:0] rd_addr,
   input  logic          flush,
   output logic [CW:0]   count,
   output logic          full,
   output logic          empty
`ifdef CIRC_BUF_ERR_FLAG_EN
   ,
   output logic          err_sticky
`endif
);

   localparam logic [CW+1:0] C_COLS   = (CW+2)'(COLUMNS);
   localparam logic [CW+1:0] C_PW     = (CW+2)'(PAR_WRITE);
   localparam logic [CW+1:0] C_PR     = (CW+2)'(PAR_READ);
   localparam logic [CW:0]   C_COLS_P = (CW+1)'(COLUMNS);
   localparam logic [CW:0]   C_PR_P   = (CW+1)'(PAR_READ);

   logic [CW-1:0] r_read_ptr;
   logic [CW:0]   r_count;

   logic [CW+1:0] w_count_ext;
   logic [CW+1:0] w_count_nxt;
   logic [CW:0]   w_rp_sum;
   logic [CW-1:0] w_rp_nxt;
   logic          w_block;
   logic          w_wr_ready;
   logic          w_rd_valid;
   logic          w_wen;
   logic          w_ren;

   // Handshake flags look only at the registered count, so a read never
   // sees entries written this cycle and a write never sees space freed.
   assign w_count_ext = {1'b0, r_count};
   assign w_block     = rst | flush;
   assign w_wr_ready  = (C_COLS - w_count_ext) >= C_PW;
   assign w_rd_valid  = w_count_ext >= C_PR;
   assign w_wen       = wr_req & w_wr_ready & ~w_block;
   assign w_ren       = rd_req & w_rd_valid & ~w_block;

   always_comb begin
      w_count_nxt = w_count_ext;
      if (w_wen)
         w_count_nxt = w_count_nxt + C_PW;
      if (w_ren)
         w_count_nxt = w_count_nxt - C_PR;
   end

   assign w_rp_sum = {1'b0, r_read_ptr} + C_PR_P;
   assign w_rp_nxt = (w_rp_sum >= C_COLS_P) ? CW'(w_rp_sum - C_COLS_P) : w_rp_sum[CW-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_read_ptr <= '0;
         r_count    <= '0;
      end else if (flush) begin
         r_read_ptr <= write_ptr;
         r_count    <= '0;
      end else begin
         r_count <= w_count_nxt[CW:0];
         if (w_ren)
            r_read_ptr <= w_rp_nxt;
      end
   end

   a_count_range: assert property (@(posedge clk) disable iff (rst) w_count_nxt <= C_COLS);

   assign wr_ready = w_wr_ready;
   assign rd_valid = w_rd_valid;
   assign wen      = w_wen;
   assign updateWP = w_wen;
   assign ren      = w_ren;
   assign wr_addr  = write_ptr;
   assign rd_addr  = r_read_ptr;
   assign count    = r_count;
   assign full     = (r_count == C_COLS_P);
   assign empty    = (r_count == '0);

`ifdef CIRC_BUF_ERR_FLAG_EN
   logic r_err;

   always_ff @(posedge clk) begin
      if (w_block)
         r_err <= 1'b0;
      else if ((wr_req & ~w_wr_ready) | (rd_req & ~w_rd_valid))
         r_err <= 1'b1;
   end

   assign err_sticky = r_err;
`endif

endmodule

// File: tb/tb_circ_buf_ctrl.sv
// tb/tb_circ_buf_ctrl.sv - table-driven scoreboard bench for circ_buf_ctrl
// Honours CIRC_BUF_ERR_FLAG_EN to also check err_sticky.
module tb_circ_buf_ctrl;

   typedef struct {
      bit rst;
      bit wr;
      bit rd;
      bit fl;
      bit e_wen;
      bit e_ren;
      int e_addr;
      int e_cnt;
      bit e_wrdy;
      bit e_rval;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_req = 1'b0;
   logic       rd_req = 1'b0;
   logic       flush = 1'b0;
   logic [4:0] write_ptr;
   logic       wr_ready, wen, updateWP, rd_valid, ren, full, empty;
   logic [4:0] wr_addr, rd_addr;
   logic [5:0] count;
`ifdef CIRC_BUF_ERR_FLAG_EN
   logic       err_sticky;
   bit         m_err = 1'b0;
`endif

   int   n_chk  = 0;
   int   n_fail = 0;
   int   wp     = 0;
   vec_t tbl[$];
   vec_t exp_q[$];

   circ_buf_ctrl #(.COLUMNS(32), .PAR_WRITE(4), .PAR_READ(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_req    (wr_req),
      .wr_ready  (wr_ready),
      .write_ptr (write_ptr),
      .wen       (wen),
      .updateWP  (updateWP),
      .wr_addr   (wr_addr),
      .rd_req    (rd_req),
      .rd_valid  (rd_valid),
      .ren       (ren),
      .rd_addr   (rd_addr),
      .flush     (flush),
      .count     (count),
      .full      (full),
      .empty     (empty)
`ifdef CIRC_BUF_ERR_FLAG_EN
      ,
      .err_sticky(err_sticky)
`endif
   );

   always #5 clk = ~clk;

   // Upstream write-pointer stage model.
   assign write_ptr = 5'(wp);
   always @(posedge clk) begin
      if (rst)
         wp <= 0;
      else if (updateWP)
         wp <= (wp + 4) % 32;
   end

   task automatic chk(input string name, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic void add(bit r, bit w, bit rd, bit f, bit ewen, bit eren,
                               int a, int c, bit wrdy, bit rval);
      vec_t v;
      v = '{r, w, rd, f, ewen, eren, a, c, wrdy, rval};
      tbl.push_back(v);
   endfunction

   task automatic drive(input vec_t v);
      rst    = v.rst;
      wr_req = v.wr;
      rd_req = v.rd;
      flush  = v.fl;
      exp_q.push_back(v);
   endtask

   always @(negedge clk) begin
      vec_t v;
      if (exp_q.size() > 0) begin
         v = exp_q.pop_front();
         chk("wen",       int'(wen),      int'(v.e_wen));
         chk("updateWP",  int'(updateWP), int'(v.e_wen));
         chk("ren",       int'(ren),      int'(v.e_ren));
         chk("rd_addr",   int'(rd_addr),  v.e_addr);
         chk("count",     int'(count),    v.e_cnt);
         chk("wr_ready",  int'(wr_ready), int'(v.e_wrdy));
         chk("rd_valid",  int'(rd_valid), int'(v.e_rval));
         chk("full",      int'(full),     int'(v.e_cnt == 32));
         chk("empty",     int'(empty),    int'(v.e_cnt == 0));
         chk("wr_addr",   int'(wr_addr),  wp);
         chk("invariant", (int'(rd_addr) + int'(count)) % 32, wp);
`ifdef CIRC_BUF_ERR_FLAG_EN
         chk("err_sticky", int'(err_sticky), int'(m_err));
         if (v.rst || v.fl)
            m_err = 1'b0;
         else if ((v.wr && !v.e_wrdy) || (v.rd && !v.e_rval))
            m_err = 1'b1;
`endif
      end
   end

   initial begin
      vec_t v;
      int   m_cnt;
      int   m_rp;

      // reset (with requests dropped), fill to full, refused 9th write
      add(1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
      for (int k = 0; k < 8; k++)
         add(0, 1, 0, 0, 1, 0, 0, 4 * k, 1, k > 0);
      add(0, 1, 0, 0, 0, 0, 0, 32, 0, 1);
      // drain 4 from full, then simultaneous write+read at 28
      for (int k = 0; k < 4; k++)
         add(0, 0, 1, 0, 0, 1, k, 32 - k, 0, 1);
      add(0, 1, 1, 0, 1, 1, 4, 28, 1, 1);
      add(0, 1, 0, 0, 0, 0, 5, 31, 0, 1);
      // read through address 31 and wrap to 0
      for (int k = 0; k < 27; k++)
         add(0, 0, 1, 0, 0, 1, 5 + k, 31 - k, (31 - k) <= 28, 1);
      // reach count=10, write_ptr=12, then flush with requests pending
      add(0, 1, 0, 0, 1, 0, 0, 4, 1, 1);
      add(0, 1, 0, 0, 1, 0, 0, 8, 1, 1);
      add(0, 0, 1, 0, 0, 1, 0, 12, 1, 1);
      add(0, 0, 1, 0, 0, 1, 1, 11, 1, 1);
      add(0, 1, 1, 1, 0, 0, 2, 10, 1, 1);
      // from empty: write accepted, read refused (no bypass)
      add(0, 1, 1, 0, 1, 0, 12, 0, 1, 0);
      add(0, 0, 1, 0, 0, 1, 12, 4, 1, 1);
      // reset mid-operation drops concurrent requests
      add(1, 1, 1, 0, 0, 0, 13, 3, 1, 1);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

      @(posedge clk);
      for (int i = 0; i < tbl.size(); i++) begin
         #1;
         drive(tbl[i]);
         @(posedge clk);
      end

      // randomized traffic against an occupancy model
      m_cnt = 0;
      m_rp  = 0;
      for (int i = 0; i < 400; i++) begin
         #1;
         v.rst    = ($urandom_range(0, 39) == 0);
         v.fl     = ($urandom_range(0, 19) == 0);
         v.wr     = ($urandom_range(0, 3) == 0);
         v.rd     = ($urandom_range(0, 2) != 0);
         v.e_addr = m_rp;
         v.e_cnt  = m_cnt;
         v.e_wrdy = (32 - m_cnt) >= 4;
         v.e_rval = m_cnt >= 1;
         v.e_wen  = v.wr && v.e_wrdy && !v.rst && !v.fl;
         v.e_ren  = v.rd && v.e_rval && !v.rst && !v.fl;
         if (v.rst) begin
            m_cnt = 0;
            m_rp  = 0;
         end else if (v.fl) begin
            m_cnt = 0;
            m_rp  = wp;
         end else begin
            m_cnt = m_cnt + (v.e_wen ? 4 : 0) - (v.e_ren ? 1 : 0);
            m_rp  = (m_rp + (v.e_ren ? 1 : 0)) % 32;
         end
         drive(v);
         @(posedge clk);
      end

      #1;
      rst    = 1'b0;
      wr_req = 1'b0;
      rd_req = 1'b0;
      flush  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
